// File: rtl/uart_msg_sequencer.sv
// UART transmit message sequencer: streams a writable byte buffer into a UART TX core over the
// XMitGo/TxEmpty handshake, one-shot or repeating with a fixed idle gap between passes.
module uart_msg_sequencer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned GAP_CYCLES = 38_399
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode,
  input  logic              Abort,
  input  logic [ADDR_W:0]   MsgLen,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              TxEmpty,
  output logic              XMitGo,
  output logic [DATA_W-1:0] TxData,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] ByteIdx
);

  localparam int unsigned     GapW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast  = GapW'(GAP_CYCLES - 1);
  localparam logic [ADDR_W:0] DepthLen = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitEmpty,
    StSend,
    StWaitBusy,
    StGap
  } state_e;

  state_e            state_q;
  logic [ADDR_W:0]   len_q;
  logic              mode_q;
  logic [GapW-1:0]   gap_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   next_idx;
  logic [ADDR_W:0]   start_len;

  always_comb begin
    next_idx  = {1'b0, ByteIdx} + (ADDR_W + 1)'(1);
    start_len = (MsgLen > DepthLen) ? DepthLen : MsgLen;
  end

  // Buffer is never cleared; a write in the same cycle as a fetch of that entry lands after the
  // read, so the fetch returns the old byte.
  always_ff @(posedge Clock) begin
    if (WrEn) begin
      mem_q[WrAddr] <= WrData;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      mode_q  <= 1'b0;
      gap_q   <= '0;
      XMitGo  <= 1'b0;
      TxData  <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      ByteIdx <= '0;
    end else begin
      XMitGo <= 1'b0;
      Done   <= 1'b0;
      if (Abort) begin
        state_q <= StIdle;
        Busy    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (Start) begin
              if (MsgLen != '0) begin
                len_q   <= start_len;
                mode_q  <= Mode;
                ByteIdx <= '0;
                Busy    <= 1'b1;
                state_q <= StFetch;
              end else begin
                Done <= 1'b1;
              end
            end
          end
          StFetch: begin
            TxData  <= mem_q[ByteIdx];
            state_q <= StWaitEmpty;
          end
          StWaitEmpty: begin
            if (TxEmpty) begin
              XMitGo  <= 1'b1;
              state_q <= StSend;
            end
          end
          StSend: begin
            state_q <= StWaitBusy;
          end
          // TxEmpty falling is the TX core's acknowledgement that it took the byte.
          StWaitBusy: begin
            if (!TxEmpty) begin
              if (next_idx < len_q) begin
                ByteIdx <= next_idx[ADDR_W-1:0];
                state_q <= StFetch;
              end else begin
                Done <= 1'b1;
                if (mode_q) begin
                  gap_q   <= '0;
                  state_q <= StGap;
                end else begin
                  Busy    <= 1'b0;
                  state_q <= StIdle;
                end
              end
            end
          end
          StGap: begin
            if (gap_q == GapLast) begin
              ByteIdx <= '0;
              state_q <= StFetch;
            end else begin
              gap_q <= gap_q + GapW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            Busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
